inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch stage: the producer side of the ID-stage interface. Generates the PC,
//  runs a single-outstanding req/ack handshake to instruction memory, and registers
//  pc/instruction into the IF/ID pipeline register.
//  Honours the decoder's stall request and branch redirect (br/br_addr). Inserts NOP bubbles
//  on memory wait and on wrong-path fetches.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  NOP_INST  32'h0000_0013  bubble instruction (addi x0,x0,0) driven on id_inst when invalid
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   reset, synchronous, active-high
//  stall       in   1   stall request from ID/control; freezes the IF/ID register
//  br          in   1   branch/jump taken, resolved by ID for the instruction in IF/ID
//  br_addr     in   32  redirect target; bits[1:0] are ignored (treated as 0)
//  imem_req    out  1   instruction memory request valid
//  imem_addr   out  32  request address, word aligned
//  imem_ack    in   1   memory response valid; one cycle per request
//  imem_rdata  in   32  instruction word; valid only when imem_ack=1
//  id_pc       out  32  PC of the instruction in IF/ID
//  id_inst     out  32  instruction in IF/ID (NOP_INST when id_valid=0)
//  id_valid    out  1   IF/ID holds a real, on-path instruction
// BEHAVIOUR
//  - Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, id_pc=0,
//    id_inst=NOP_INST, id_valid=0, hold register cleared. A reset mid-handshake abandons
//    the request; an ack arriving in IDLE is ignored.
//  - Priority each cycle: rst > stall > br > normal advance.
//  - States:
//    - IDLE: imem_req=0. Next cycle goes to FETCH.
//    - FETCH: imem_req=1, imem_addr=pc. Addr is held stable until imem_ack.
//      - ack & !stall & !br: id_pc<=pc, id_inst<=rdata, id_valid<=1, pc<=pc+4; stay FETCH.
//        This gives back-to-back fetch, 1 instr/cycle with zero-wait memory.
//      - ack & stall: rdata and pc go into the hold register; pc<=pc+4; go HOLD; IF/ID unchanged.
//      - !ack & !stall & !br: IF/ID <= bubble (id_inst=NOP_INST, id_valid=0; id_pc unchanged).
//      - br & !stall & ack: rdata is discarded; pc<=br_addr&~3; IF/ID<=bubble; stay FETCH.
//      - br & !stall & !ack: latch target; IF/ID<=bubble; go DRAIN.
//    - DRAIN: keep imem_req=1 with the old addr until ack (a request is never withdrawn).
//      On ack, discard rdata, pc<=target, go FETCH. IF/ID stays bubble unless stall.
//    - HOLD: imem_req=0. When stall falls, the hold register moves to IF/ID (id_valid=1); go FETCH.
//      If br=1 in the same cycle stall falls, the hold entry is discarded, pc<=br_addr&~3,
//      IF/ID<=bubble; go FETCH.
//  - stall=1: IF/ID (id_pc, id_inst, id_valid) holds exactly; br is ignored.
//    An outstanding request still completes into the hold register.
//  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
//  - Latency: address presented in cycle N with ack in N gives id_inst valid at N+1.
//    From br sampled to first target instruction in IF/ID: 2 cycles with zero-wait memory.
// CONFIGURATION
//  IF_PERF_CNT_EN defined:
//    - adds outputs perf_fetch_cnt[31:0] (on-path instructions loaded into IF/ID)
//      and perf_bubble_cnt[31:0] (bubbles loaded into IF/ID).
//    - both reset to 0 and wrap on overflow; neither counts while stall=1.
//  IF_PERF_CNT_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//  1. Reset, then zero-wait memory returning addr as data: id_pc=0,4,8,C on consecutive cycles,
//     id_valid=1, id_inst==id_pc.
//  2. Memory acks every 3rd cycle: IF/ID shows 2 bubbles (NOP_INST 0x13, id_valid=0) between
//     valid instrs; imem_addr stays stable until ack.
//  3. stall=1 for 4 cycles with an ack during the stall: IF/ID frozen, imem_req=0 after the ack.
//     After stall falls, the held instr appears next cycle; no instruction is lost or duplicated.
//  4. br=1, br_addr=32'h0000_0103 with ack in the same cycle: next imem_addr=0x100, one bubble,
//     then id_pc=0x100.
//  5. br=1 while a request is pending, ack 2 cycles later: the old response is discarded,
//     the next request goes to the target, and no wrong-path id_valid=1 appears.
//  6. Start at RESET_PC=32'hFFFF_FFF8: fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
//     rst asserted mid-DRAIN returns to RESET_PC with all outputs at reset values the next cycle.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: PC generation, single-outstanding imem req/ack and IF/ID register with stall/branch handling.
// Define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_bubble_cnt counters.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] br_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;
    state_t state;
    logic [31:0] pc, target, hold_pc, hold_inst, br_tgt, pc_inc;
    logic ld_inst, ld_bubble;
    // IF/ID load decisions; stall freezes the register regardless of state
    always_comb begin
        br_tgt = br_addr & ~32'd3;
        pc_inc = pc + 32'd4;
        ld_inst = !stall && !br && ((state == FETCH && imem_ack) || state == HOLD);
        ld_bubble = !stall && ((state == FETCH && (br || !imem_ack)) || state == DRAIN || (state == HOLD && br));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            target <= '0;
            hold_pc <= '0;
            hold_inst <= '0;
            imem_req <= 1'b0;
            imem_addr <= RESET_PC;
            id_pc <= '0;
            id_inst <= NOP_INST;
            id_valid <= 1'b0;
        end else begin
            if (ld_inst) begin
                id_pc <= state == HOLD ? hold_pc : pc;
                id_inst <= state == HOLD ? hold_inst : imem_rdata;
                id_valid <= 1'b1;
            end else if (ld_bubble) begin
                id_inst <= NOP_INST;
                id_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    state <= FETCH;
                    imem_req <= 1'b1;
                    imem_addr <= pc;
                end
                FETCH: begin
                    if (stall) begin
                        if (imem_ack) begin
                            hold_pc <= pc;
                            hold_inst <= imem_rdata;
                            pc <= pc_inc;
                            imem_req <= 1'b0;
                            state <= HOLD;
                        end
                    end else if (br) begin
                        if (imem_ack) begin
                            pc <= br_tgt;
                            imem_addr <= br_tgt;
                        end else begin
                            // request cannot be withdrawn; wait out its ack before redirecting
                            target <= br_tgt;
                            state <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc <= pc_inc;
                        imem_addr <= pc_inc;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        pc <= target;
                        imem_addr <= target;
                        state <= FETCH;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (br) pc <= br_tgt;
                        imem_addr <= br ? br_tgt : pc;
                        imem_req <= 1'b1;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (ld_inst) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (ld_bubble) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized scoreboard bench for inst_fetch with a program-stream reference model.
module tb_inst_fetch;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, br = 1'b0, imem_ack = 1'b0;
    logic [31:0] br_addr = '0, imem_rdata = '0;
    logic imem_req, id_valid;
    logic [31:0] imem_addr, id_pc, id_inst;
    int total = 0, bad = 0, pops = 0;
    bit hash_mem = 1'b0, br_en = 1'b0, gap_chk = 1'b0;
    int fixed_dly = 0, stall_pct = 0;
    logic [31:0] q[$];
    logic e_rst = 1'b1, e_stall = 1'b0, e_br = 1'b0, e_ack = 1'b0, e_req = 1'b0, e_drain = 1'b0, e_hold = 1'b0;
    logic [31:0] e_addr = '0, e_br_addr = '0;
    logic drain = 1'b0, hold = 1'b0;
    int gap = 0, br_gap = 0;
    bit seen = 1'b0;
    logic [31:0] s_pc = '0, s_inst = '0, exp_pc = '0;
    logic s_valid = 1'b0;

    inst_fetch #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br(br), .br_addr(br_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
    );

    always #5 clk = ~clk;

    // program image: identity (data == address) or a hashed word stream
    function automatic logic [31:0] memf(input logic [31:0] a);
        return hash_mem ? (a ^ 32'h5555_AAAA) * 32'h9E37_79B1 : a;
    endfunction
    function automatic bit is_br(input logic [31:0] i);
        return br_en && i[31:29] == 3'b000;
    endfunction
    function automatic logic [31:0] tgt(input logic [31:0] i);
        return {16'h0000, i[15:0]};
    endfunction
    function automatic int new_dly();
        return fixed_dly < 0 ? int'($urandom_range(0, 3)) : fixed_dly;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // instruction memory: one ack per request after a programmable wait
    initial begin
        int dly = 0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req && dly == 0) begin
                imem_ack = 1'b1;
                imem_rdata = memf(imem_addr);
                dly = new_dly();
            end else begin
                imem_ack = 1'b0;
                imem_rdata = $urandom;
                dly = imem_req ? dly - 1 : new_dly();
            end
        end
    end

    // capture what the DUT saw at each edge, plus protocol-level drain/hold tracking
    always @(posedge clk) begin
        e_rst <= rst;
        e_stall <= stall;
        e_br <= br;
        e_ack <= imem_ack;
        e_req <= imem_req;
        e_addr <= imem_addr;
        e_br_addr <= br_addr;
        e_drain <= drain;
        e_hold <= hold;
        if (rst) begin
            drain <= 1'b0;
            hold <= 1'b0;
        end else begin
            drain <= drain ? !imem_ack : (br && !stall && imem_req && !imem_ack);
            hold <= hold ? stall : (stall && imem_req && imem_ack && !drain);
        end
    end

    // monitor: pops the scoreboard whenever a new valid instruction lands in IF/ID
    always @(negedge clk) begin
        if (e_rst) begin
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_addr", imem_addr, RST_PC);
            chk("rst_pc", id_pc, 32'd0);
            chk("rst_inst", id_inst, NOP);
            chk("rst_valid", {31'd0, id_valid}, 32'd0);
            seen = 1'b0;
            gap = 0;
            br_gap = 0;
        end else begin
            if (e_req && !e_ack) begin
                chk("req_stable", {31'd0, imem_req}, 32'd1);
                chk("addr_stable", imem_addr, e_addr);
            end
            if (e_stall) begin
                chk("frz_pc", id_pc, s_pc);
                chk("frz_inst", id_inst, s_inst);
                chk("frz_valid", {31'd0, id_valid}, {31'd0, s_valid});
                if ((e_req && e_ack && !e_drain) || e_hold) chk("hold_req", {31'd0, imem_req}, 32'd0);
            end else begin
                if (e_hold && !e_br) chk("hold_rel", {31'd0, id_valid}, 32'd1);
                if (e_br && ((e_req && e_ack) || e_hold)) begin
                    chk("br_req", {31'd0, imem_req}, 32'd1);
                    chk("br_addr", imem_addr, e_br_addr & ~32'd3);
                end
                if (id_valid) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty: got pc %h expected none", id_pc);
                    end else begin
                        exp_pc = q.pop_front();
                        chk("sb_pc", id_pc, exp_pc);
                        chk("sb_inst", id_inst, memf(exp_pc));
                    end
                    if (gap_chk && seen) chk("gap", gap, fixed_dly + br_gap);
                    seen = 1'b1;
                    gap = 0;
                    br_gap = 0;
                    pops++;
                end else begin
                    chk("bubble", id_inst, NOP);
                    gap++;
                    if (e_br) br_gap = 1;
                end
            end
        end
        s_pc = id_pc;
        s_inst = id_inst;
        s_valid = id_valid;
    end

    // acts as the ID stage: branches when the instruction in IF/ID decodes as one
    task automatic drive_one();
        stall = ($urandom_range(0, 99) < stall_pct);
        br = !stall && id_valid && is_br(id_inst);
        br_addr = br ? tgt(id_inst) : $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic run_phase(input bit hm, input int fd, input int sp, input bit be, input bit gc, input int n);
        int start, cyc;
        logic [31:0] p;
        rst = 1'b1;
        stall = 1'b0;
        br = 1'b0;
        @(posedge clk);
        #1;
        hash_mem = hm;
        fixed_dly = fd;
        stall_pct = sp;
        br_en = be;
        gap_chk = gc;
        q.delete();
        p = RST_PC;
        repeat (n + 50) begin
            q.push_back(p);
            p = is_br(memf(p)) ? (tgt(memf(p)) & ~32'd3) : p + 32'd4;
        end
        rst = 1'b0;
        start = pops;
        cyc = 0;
        while (pops - start < n && cyc < 4000) begin
            drive_one();
            cyc++;
        end
        if (cyc >= 4000) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d instrs expected %0d", pops - start, n);
        end
    endtask

    initial begin
        int c;
        run_phase(1'b0, 0, 0, 1'b0, 1'b1, 20);
        run_phase(1'b0, 2, 0, 1'b0, 1'b1, 20);
        run_phase(1'b1, 0, 0, 1'b1, 1'b1, 60);
        run_phase(1'b1, -1, 25, 1'b1, 1'b0, 300);
        run_phase(1'b1, 3, 0, 1'b1, 1'b0, 30);
        c = 0;
        while (!drain && c < 2000) begin
            drive_one();
            c++;
        end
        if (!drain) begin
            total++;
            bad++;
            $display("FAIL drain_reach: got no drain expected drain");
        end
        run_phase(1'b1, -1, 30, 1'b1, 1'b0, 200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
